// File: rtl/l2_per_apb_responder.sv
// L2 peripheral request port to APB3 bridge.
// Accepts one req/gnt transaction at a time, runs it as an APB SETUP/ACCESS
// pair and returns a single r_valid pulse with rdata, error flag and aux tag.
// A hung peripheral is aborted after TIMEOUT_CYCLES ACCESS cycles and reported
// as an error response carrying the 0xBADACCE5 pattern.
module l2_per_apb_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int AUX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [AUX_WIDTH-1:0]  data_aux_i,
    output logic                  data_gnt_o,
    output logic                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  data_r_opc_o,
    output logic [AUX_WIDTH-1:0]  data_r_aux_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [BE_WIDTH-1:0]   pstrb_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADA_CCE5);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [AUX_WIDTH-1:0] aux_q;
    logic                 grant;
    logic                 timeout_hit;

    assign grant       = data_req_i && (state == IDLE || state == RESP);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && !pready_i && (cnt == CNT_LAST);

    // State register; reset drops any in-flight access without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode: grants only from IDLE/RESP, pready beats the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready_i || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = grant ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state so they fall with the async reset.
    always_comb begin
        data_gnt_o     = grant;
        psel_o         = (state == SETUP) || (state == ACCESS);
        penable_o      = (state == ACCESS);
        data_r_valid_o = (state == RESP);
    end

    // Request latch: capture the granted transaction for the APB side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_o  <= '0;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
            aux_q    <= '0;
        end else if (grant) begin
            paddr_o  <= data_add_i;
            pwrite_o <= !data_wen_i;
            pwdata_o <= data_wdata_i;
            pstrb_o  <= data_wen_i ? '0 : data_be_i;
            aux_q    <= data_aux_i;
        end
    end

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               cnt <= '0;
        else if (state == SETUP)               cnt <= '0;
        else if (state == ACCESS && !pready_i) cnt <= cnt + 1'b1;
    end

    // Response registers: loaded on completion or abort, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r_rdata_o <= '0;
            data_r_opc_o   <= 1'b0;
            data_r_aux_o   <= '0;
        end else if (state == ACCESS) begin
            if (pready_i) begin
                data_r_rdata_o <= pwrite_o ? '0 : prdata_i;
                data_r_opc_o   <= pslverr_i;
                data_r_aux_o   <= aux_q;
            end else if (timeout_hit) begin
                data_r_rdata_o <= ERR_DATA;
                data_r_opc_o   <= 1'b1;
                data_r_aux_o   <= aux_q;
            end
        end
    end

endmodule

// File: tb/tb_l2_per_apb_responder.sv
// Self-checking bench for l2_per_apb_responder with a 16-cycle timeout.
// A behavioural APB slave answers each access after a per-vector wait count;
// expected responses are queued at grant time and compared on r_valid.
module tb_l2_per_apb_responder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [3:0]  aux = '0;
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic [3:0]  r_aux;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  aux;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_opc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        logic [3:0]  aux;
    } resp_t;

    resp_t sb[$];
    vec_t  apb_q[$];
    vec_t  vecs[8];

    l2_per_apb_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .AUX_WIDTH(4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_aux_i(aux),
        .data_gnt_o(gnt), .data_r_valid_o(r_valid), .data_r_rdata_o(r_rdata),
        .data_r_opc_o(r_opc), .data_r_aux_o(r_aux),
        .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
        .pwdata_o(pwdata), .pstrb_o(pstrb),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(logic rd, logic [31:0] a, logic [31:0] wd, logic [3:0] b,
                                logic [3:0] ax, int w, logic se, logic [31:0] pd,
                                logic [31:0] er, logic eo);
        vec_t v;
        v.rd = rd; v.addr = a; v.wdata = wd; v.be = b; v.aux = ax; v.waits = w;
        v.slverr = se; v.prdata = pd; v.exp_rdata = er; v.exp_opc = eo;
        return v;
    endfunction

    // Response monitor: every r_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && r_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 1, 0);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("r_rdata", r_rdata, e.rdata);
                chk("r_opc", r_opc, e.opc);
                chk("r_aux", r_aux, e.aux);
            end
        end
    end

    // APB slave model: answers after cur.waits stall cycles, checks bus fields.
    vec_t cur;
    int   acc = 0;
    bit   active = 0;
    always @(negedge clk) begin
        if (rst) begin
            active = 0; pready = 0; pslverr = 0;
        end else if (psel && !penable) begin
            pready = 0; pslverr = 0;
            if (apb_q.size() == 0) begin
                chk("setup_without_txn", 1, 0);
            end else begin
                cur = apb_q.pop_front();
                active = 1; acc = 0;
                chk("setup_paddr", paddr, cur.addr);
            end
        end else if (psel && penable) begin
            acc++;
            chk("no_gnt_in_access", gnt, 0);
            chk("paddr", paddr, cur.addr);
            chk("pwrite", pwrite, !cur.rd);
            chk("pstrb", pstrb, cur.rd ? 4'h0 : cur.be);
            if (!cur.rd) chk("pwdata", pwdata, cur.wdata);
            pready  = (acc == cur.waits + 1);
            pslverr = pready ? cur.slverr : 1'b0;
            prdata  = pready ? cur.prdata : 32'h5A5A_5A5A;
        end else begin
            if (active) begin
                chk("access_len", acc, (cur.waits + 1 < TO) ? cur.waits + 1 : TO);
                active = 0;
            end
            pready = 0; pslverr = 0;
        end
    end

    // Present a request at a falling edge and hold it until granted.
    task automatic issue(input vec_t v);
        int n;
        resp_t e;
        @(negedge clk);
        req = 1; add = v.addr; wen = v.rd; wdata = v.wdata; be = v.be; aux = v.aux;
        #1;
        n = 0;
        while (!gnt && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!gnt) begin
            chk("gnt_timeout", 0, 1);
        end else begin
            e.rdata = v.exp_rdata; e.opc = v.exp_opc; e.aux = v.aux;
            sb.push_back(e);
            apb_q.push_back(v);
        end
    endtask

    task automatic req_off();
        @(negedge clk);
        req = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 32'h1A10_0004, 32'h0, 4'hF, 4'd5, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        vecs[1] = mk(0, 32'h1A10_0008, 32'h1234_5678, 4'b0011, 4'd2, 3, 0, 32'hFFFF_FFFF, 32'h0, 0);
        vecs[2] = mk(1, 32'h1A10_000C, 32'h0, 4'hF, 4'd9, 0, 1, 32'h0000_1111, 32'h0000_1111, 1);
        vecs[3] = mk(1, 32'h1A10_0010, 32'h0, 4'hF, 4'd3, 30, 0, 32'h1, 32'hBADA_CCE5, 1);
        vecs[4] = mk(1, 32'h1A10_0014, 32'h0, 4'hF, 4'd4, TO - 1, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
        vecs[5] = mk(1, 32'h1A10_0018, 32'h0, 4'hF, 4'd6, TO, 0, 32'h2, 32'hBADA_CCE5, 1);
        vecs[6] = mk(0, 32'h1A10_001C, 32'hA5A5_0F0F, 4'hF, 4'd7, TO - 1, 1, 32'h3, 32'h0, 1);
        vecs[7] = mk(1, 32'h1A10_0020, 32'h0, 4'hF, 4'd8, 1, 0, 32'h7777_0000, 32'h7777_0000, 0);

        // reset state
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rvalid", r_valid, 0);
        chk("rst_rdata", r_rdata, 0);
        chk("rst_opc", r_opc, 0);
        chk("rst_raux", r_aux, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_gnt", gnt, 0);
        @(negedge clk);
        rst = 0;

        // minimum latency read: psel T+1, penable T+2, r_valid T+3
        issue(vecs[0]);
        chk("t0_gnt_idle_psel", psel, 0);
        req_off();
        chk("t1_psel", psel, 1);
        chk("t1_penable", penable, 0);
        @(negedge clk);
        chk("t2_psel", psel, 1);
        chk("t2_penable", penable, 1);
        @(negedge clk);
        chk("t3_rvalid", r_valid, 1);
        drain();

        // table-driven vectors: waits, slave error and timeout boundaries
        for (int i = 1; i < 8; i++) begin
            issue(vecs[i]);
            req_off();
            drain();
            chk("idle_after_resp", psel, 0);
        end

        // back-to-back: second request granted in the RESP cycle
        issue(mk(1, 32'h1A10_0100, 32'h0, 4'hF, 4'hA, 2, 0, 32'h0A0A_0A0A, 32'h0A0A_0A0A, 0));
        issue(mk(0, 32'h1A10_0104, 32'h5555_AAAA, 4'b1100, 4'hB, 0, 0, 32'h9, 32'h0, 0));
        chk("b2b_gnt_in_resp", r_valid, 1);
        req_off();
        chk("b2b_setup_psel", psel, 1);
        chk("b2b_setup_penable", penable, 0);
        drain();

        // reset during ACCESS drops the access with no response
        issue(mk(1, 32'h1A10_0200, 32'h0, 4'hF, 4'hC, 30, 0, 32'h4, 32'hBADA_CCE5, 1));
        req_off();
        @(negedge clk);
        chk("pre_rst_penable", penable, 1);
        #2;
        rst = 1;
        #1;
        chk("async_rst_psel", psel, 0);
        chk("async_rst_penable", penable, 0);
        chk("async_rst_rvalid", r_valid, 0);
        sb.delete();
        apb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        repeat (TO + 4) @(negedge clk);
        chk("post_rst_psel", psel, 0);
        issue(mk(1, 32'h1A10_0204, 32'h0, 4'hF, 4'hD, 1, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0));
        req_off();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
